// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter in front of a single-port memory.
// Requester 0 is the im2col engine and requester 1 is the GEMM/host port.
// Grants are combinational on top of a registered IDLE/GRANT0/GRANT1 FSM.
// An 8-bit beat counter bounds a burst so that a waiting requester is not starved.
// Optional build macro: ARB_FIXED_PRIO_EN. When it is defined, IDLE ties go to
// requester 0 and only requester 1 is limited by MAX_BURST.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] beat_cnt;
  logic       last_served;
  logic       limit0, limit1;
  logic       tie_pick1;

  assign gnt0 = (state == GRANT0) && req0;
  assign gnt1 = (state == GRANT1) && req1;

  // Burst limit and tie-break policy. The >= compare means a requester that
  // arrives after a long solo burst is served right after the current beat.
`ifdef ARB_FIXED_PRIO_EN
  assign limit0    = 1'b0;
  assign tie_pick1 = 1'b0;
`else
  assign limit0    = (beat_cnt >= BURST_LAST);
  assign tie_pick1 = ~last_served;
`endif
  assign limit1 = (beat_cnt >= BURST_LAST);

  // Memory command mux; an idle port drives all zeros.
  assign mem_en    = gnt0 | gnt1;
  assign mem_we    = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
  assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
  assign rdata     = mem_rdata;

  // Next-state logic: round robin from IDLE, yield at burst end or on request drop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = tie_pick1 ? GRANT1 : GRANT0;
        else if (req0)    state_nxt = GRANT0;
        else if (req1)    state_nxt = GRANT1;
      end
      GRANT0: begin
        if (req0) begin
          if (limit0 && req1) state_nxt = GRANT1;
        end else begin
          state_nxt = req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (req1) begin
          if (limit1 && req0) state_nxt = GRANT0;
        end else begin
          state_nxt = req0 ? GRANT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, beat counter and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat_cnt    <= 8'd0;
      last_served <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        beat_cnt <= 8'd0;
      else if (mem_en && (beat_cnt != 8'hFF))
        beat_cnt <= beat_cnt + 8'd1;
      if (gnt0)      last_served <= 1'b0;
      else if (gnt1) last_served <= 1'b1;
    end
  end

  // Read-valid flags track the one-cycle memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a read-data scoreboard.
// The bench holds a behavioural memory that answers the DUT's command port, and
// a separate shadow memory built from requester-side writes that supplies the
// expected read data. Uses MAX_BURST=4 and honours ARB_FIXED_PRIO_EN when it is set.
module tb_mem_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Monitor: command-port checks on every grant, scoreboard push/pop for reads.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
      if (rvalid0) begin
        chk("rv0_expected", {31'd0, q0.size() != 0}, 32'd1);
        if (q0.size() != 0) chk("rdata0", {24'd0, rdata}, {24'd0, q0.pop_front()});
      end
      if (rvalid1) begin
        chk("rv1_expected", {31'd0, q1.size() != 0}, 32'd1);
        if (q1.size() != 0) chk("rdata1", {24'd0, rdata}, {24'd0, q1.pop_front()});
      end
      if (gnt0) begin
        chk("cmd0_en", {31'd0, mem_en}, 32'd1);
        chk("cmd0_we", {31'd0, mem_we}, {31'd0, we0});
        chk("cmd0_addr", mem_addr, addr0);
        if (we0) ref_mem[addr0[7:0]] = wdata0;
        else     q0.push_back(ref_mem[addr0[7:0]]);
      end
      if (gnt1) begin
        chk("cmd1_en", {31'd0, mem_en}, 32'd1);
        chk("cmd1_we", {31'd0, mem_we}, {31'd0, we1});
        chk("cmd1_addr", mem_addr, addr1);
        if (we1) ref_mem[addr1[7:0]] = wdata1;
        else     q1.push_back(ref_mem[addr1[7:0]]);
      end
      if (!gnt0 && !gnt1) chk("idle_en", {31'd0, mem_en}, 32'd0);
    end
  end

  initial begin
    int first_g1;
    int n_g1;
    logic e0, e1;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    cyc(); rst_n = 1'b1;

    // Single read from requester 0: one-cycle arbitration latency
    cyc(); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk); chk("lat_no_gnt", {31'd0, gnt0}, 32'd0);
    cyc();
    @(negedge clk);
    chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rd_addr", mem_addr, 32'h10);
    chk("rd_we", {31'd0, mem_we}, 32'd0);
    cyc(); req0 = 1'b0;
    @(negedge clk);
    chk("rd_rvalid0", {31'd0, rvalid0}, 32'd1);
    chk("rd_rdata", {24'd0, rdata}, {24'd0, 8'h10 ^ 8'h5A});
    cyc(); cyc();

    // Both requesters held: 4-beat alternation with no idle gap
    cyc(); req0 = 1'b1; req1 = 1'b1; addr0 = 32'h20; addr1 = 32'h30;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k == 0) begin e0 = 1'b0; e1 = 1'b0; end
      else begin
`ifdef ARB_FIXED_PRIO_EN
        e0 = 1'b1; e1 = 1'b0;
`else
        e1 = (((k - 1) / MB) % 2) == 0;
        e0 = ~e1;
`endif
      end
      chk("burst_g0", {31'd0, gnt0}, {31'd0, e0});
      chk("burst_g1", {31'd0, gnt1}, {31'd0, e1});
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();

    // Requester 1 drops while 0 waits; then write and read back through port 0
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h31;
    @(negedge clk); chk("h_idle", {31'd0, gnt1}, 32'd0);
    cyc(); req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 8'hA5;
    @(negedge clk); chk("h_g1_on", {31'd0, gnt1}, 32'd1);
    cyc(); req1 = 1'b0;
    @(negedge clk); chk("h_gap", {30'd0, gnt0, gnt1}, 32'd0);
    cyc();
    @(negedge clk);
    chk("h_g0_next", {31'd0, gnt0}, 32'd1);
    chk("h_wr_we", {31'd0, mem_we}, 32'd1);
    chk("h_wr_data", {24'd0, mem_wdata}, 32'hA5);
    cyc(); we0 = 1'b0;
    @(negedge clk); chk("h_rd_gnt", {31'd0, gnt0}, 32'd1);
    cyc(); req0 = 1'b0;
    @(negedge clk);
    chk("h_rd_rvalid", {31'd0, rvalid0}, 32'd1);
    chk("h_rd_data", {24'd0, rdata}, 32'hA5);
    cyc(); cyc();

    // Reset pulsed during a GRANT0 read burst
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h11;
    cyc(); cyc();
    @(negedge clk); chk("mr_pre_rvalid", {31'd0, rvalid0}, 32'd1);
    cyc(); rst_n = 1'b0; #1;
    chk("mr_gnt0", {31'd0, gnt0}, 32'd0);
    chk("mr_mem_en", {31'd0, mem_en}, 32'd0);
    chk("mr_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("mr_gnt1", {31'd0, gnt1}, 32'd0);
    cyc(); rst_n = 1'b1;
    @(negedge clk); chk("mr_no_grant", {30'd0, gnt0, gnt1}, 32'd0);
    cyc();
    @(negedge clk); chk("mr_regrant", {31'd0, gnt0}, 32'd1);

    // Starvation check with both requesters held for 40 cycles
    cyc(); req1 = 1'b1; we1 = 1'b0; addr1 = 32'h32;
    first_g1 = -1; n_g1 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt1) begin
        n_g1++;
        if (first_g1 < 0) first_g1 = k;
      end
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc(); cyc();
`ifdef ARB_FIXED_PRIO_EN
    chk("fp_gnt1_count", n_g1, 32'd0);
`else
    chk("rr_gnt1_seen", {31'd0, (first_g1 >= 0) && (first_g1 <= MB + 1)}, 32'd1);
`endif

    chk("sb_q0_empty", q0.size(), 32'd0);
    chk("sb_q1_empty", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
